idli_fetch_m: RTL and testbench
===============================

Name: idli_fetch_m

Overview:
Instruction fetch stage sitting directly upstream of the execution stage. It owns the free-running sync counter and drives a nibble-wide SQI SRAM (23LC1024-style, fast read command 0x0B). It streams sequential 16-bit instruction encodings, one nibble per cycle, aligned so that nibble 0 of each word appears at ctr==0. On redirect it aborts the stream and re-issues the read at the new address.

Parameters:
ADDR_NIBBLES, 6, number of address nibbles sent to SRAM (24-bit byte address).
DUMMY_NIBBLES, 2, dummy cycles between address and data (one dummy byte).

Ports:
i_fe_gck  in  1  clock; SRAM SCK is the same clock.
i_fe_rst  in  1  synchronous reset, active-high.
i_fe_redir  in  1  redirect request, single-cycle pulse.
i_fe_redir_addr  in  16  redirect target word address.
o_fe_ctr  out  2  sync counter (ctr_t); consumers treat ctr==3 as the word boundary.
o_fe_enc  out  4  encoding nibble (data_t).
o_fe_enc_vld  out  1  o_fe_enc belongs to a valid fetched word.
o_fe_pc  out  16  word address of the word currently on o_fe_enc.
o_fe_mem_cs_n  out  1  SRAM chip select, active-low.
o_fe_mem_sio  out  4  nibble driven to SRAM.
o_fe_mem_sio_oe  out  1  1 = fetch drives the SIO bus.
i_fe_mem_sio  in  4  nibble returned by SRAM.

Behaviour:
- Reset values: ctr=0, enc=0, enc_vld=0, pc=0, cs_n=1, sio=0, sio_oe=0, FSM=IDLE, fetch address=0. All outputs are registered.
- ctr increments by 1 every cycle and wraps 3->0. It is never affected by redirect; it is cleared only by reset.
- OVH = 2+ADDR_NIBBLES+DUMMY_NIBBLES (10 by default). START = (3-OVH) mod 4 (1 by default).
- States:
  - IDLE: cs_n=1 for exactly one cycle, then WAIT.
  - WAIT: cs_n=1 until ctr==START, then CMD.
  - CMD: 2 cycles. cs_n=0, oe=1, sio=0x0 then 0xB.
  - ADDR: ADDR_NIBBLES cycles, MSB nibble first. Byte address = {zero-extend, fetch_addr, 1'b0}.
  - DUMMY: DUMMY_NIBBLES cycles, oe=0, sio=0.
  - STREAM: oe=0, cs_n=0.
- Data path:
  - In STREAM, the SRAM returns nibble n in cycle S+n, where S is the first STREAM cycle. The fetch registers it and presents it on o_fe_enc in cycle S+n+1 (1-cycle latency).
  - enc_vld=1 for those presented nibbles. Nibble 0 lands at ctr==0.
  - Nibble k of a word is bits [4k+3:4k], so the SRAM image is stored LSB-nibble first.
- PC:
  - o_fe_pc = fetch_addr during the first word.
  - Increments by 1 on each ctr 3->0 transition while streaming, so it always names the word on o_fe_enc.
- Wrap: after the word at 0xFFFF completes (ctr==3 with pc==0xFFFF), raise an internal redirect to 0x0000. Behaviour is identical to an external redirect.
- Redirect (i_fe_redir=1 in cycle R, any state):
  - In R+1: cs_n=1, oe=0, enc_vld=0, fetch_addr=i_fe_redir_addr, FSM=IDLE.
  - A partially delivered word is discarded; its remaining nibbles have enc_vld=0.
  - enc_vld is 0 from R+1 until the first nibble of the new word at a later ctr==0.
- Priorities: reset > external redirect > internal wrap redirect. A redirect during IDLE/WAIT/CMD/ADDR/DUMMY restarts from IDLE with the new address. The last redirect wins.
- Reset mid-operation: all state returns to reset values in the next cycle. cs_n goes high immediately (registered, 1 cycle).
- enc while enc_vld=0: o_fe_enc holds 0.

Test Plan:
1. Reset release, SRAM word0=0x1234:
   - Bus: cs_n falls at ctr==1.
   - sio=0,B,0,0,0,0,0,0 with oe=1 for 8 cycles, then oe=0 for 2 cycles.
   - enc=4,3,2,1 at ctr=0..3 with enc_vld=1 and pc=0.
2. Sequential stream 0x1234,0xABCD,0x0F00 -> enc 4,3,2,1,D,C,B,A,0,0,F,0; pc 0,1,2; enc_vld held high throughout.
3. Redirect to 0x0100 pulsed at ctr==1 mid-word:
   - Next cycle: cs_n=1, enc_vld=0.
   - Address nibbles 0,0,0,2,0,0.
   - First new nibble at ctr==0 with pc=0x0100.
4. Redirect to 0xFFFF:
   - Word 0xFFFF streams.
   - At its ctr==3, cs_n rises next cycle.
   - Read re-issued with address 0; pc=0x0000 on the next valid word.
5. Redirect during the ADDR phase (to 0x0010), then a second redirect 2 cycles later (to 0x0020) -> only 0x0020 is fetched; address nibbles 0,0,0,0,4,0.
6. Reset asserted mid-STREAM with a simultaneous redirect:
   - Next cycle: all outputs at reset values, ctr=0.
   - Fetch restarts at address 0; the redirect is ignored.

Source files
------------

// File: rtl/idli_fetch_m.sv
// Instruction fetch: streams 16-bit encodings from an SQI SRAM one nibble per cycle, nibble 0 at ctr==0.
// All outputs registered; SRAM nibble to o_fe_enc is 1 cycle; redirect aborts the stream and restarts the read.
module idli_fetch_m #(
    parameter int ADDR_NIBBLES  = 6,
    parameter int DUMMY_NIBBLES = 2
) (
    input  logic        i_fe_gck,
    input  logic        i_fe_rst,
    input  logic        i_fe_redir,
    input  logic [15:0] i_fe_redir_addr,
    output logic [1:0]  o_fe_ctr,
    output logic [3:0]  o_fe_enc,
    output logic        o_fe_enc_vld,
    output logic [15:0] o_fe_pc,
    output logic        o_fe_mem_cs_n,
    output logic [3:0]  o_fe_mem_sio,
    output logic        o_fe_mem_sio_oe,
    input  logic [3:0]  i_fe_mem_sio
);

    localparam int          AW        = 4 * ADDR_NIBBLES;
    localparam int          OVH       = 2 + ADDR_NIBBLES + DUMMY_NIBBLES;
    localparam logic [1:0]  START     = 2'((3 - (OVH % 4) + 4) % 4);
    // WAIT leaves one cycle early so the first CMD cycle itself lands on START.
    localparam logic [1:0]  PRE_START = 2'((int'(START) + 3) % 4);

    typedef enum logic [2:0] {IDLE, WAIT, CMD, ADDR, DUMMY, STREAM} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [15:0] fetch_addr, fetch_addr_d;
    logic [15:0] pc_d;
    logic [3:0]  enc_d, sio_d, nib_sel;
    logic        vld_d, cs_n_d, oe_d;
    logic        wrap, redir;
    logic [15:0] redir_tgt;
    logic [AW-1:0] byte_addr;

    // The word at 0xFFFF is on the bus and finishing: wrap to word 0 like an external redirect.
    assign wrap      = o_fe_enc_vld && (o_fe_ctr == 2'd3) && (o_fe_pc == 16'hFFFF);
    assign redir     = i_fe_redir || wrap;
    assign redir_tgt = i_fe_redir ? i_fe_redir_addr : 16'h0000;
    assign byte_addr = AW'({fetch_addr, 1'b0});

    always_comb begin
        state_d      = state;
        cnt_d        = cnt + 4'd1;
        fetch_addr_d = fetch_addr;
        pc_d         = o_fe_pc;
        sio_d        = 4'h0;
        nib_sel      = 4'h0;

        case (state)
            IDLE: begin
                state_d = WAIT;
                cnt_d   = 4'd0;
            end
            WAIT: begin
                cnt_d = 4'd0;
                if (o_fe_ctr == PRE_START) state_d = CMD;
            end
            CMD: begin
                if (cnt == 4'd1) begin
                    state_d = ADDR;
                    cnt_d   = 4'd0;
                end
            end
            ADDR: begin
                if (cnt == 4'(ADDR_NIBBLES - 1)) begin
                    state_d = DUMMY;
                    cnt_d   = 4'd0;
                end
            end
            DUMMY: begin
                if (cnt == 4'(DUMMY_NIBBLES - 1)) begin
                    state_d = STREAM;
                    cnt_d   = 4'd0;
                end
            end
            STREAM: cnt_d = 4'd0;
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (redir) begin
            state_d      = IDLE;
            cnt_d        = 4'd0;
            fetch_addr_d = redir_tgt;
            pc_d         = redir_tgt;
        end else if (o_fe_enc_vld && (o_fe_ctr == 2'd3)) begin
            pc_d = o_fe_pc + 16'd1;
        end

        cs_n_d = (state_d == IDLE) || (state_d == WAIT);
        oe_d   = (state_d == CMD) || (state_d == ADDR);
        if (state_d == CMD) begin
            sio_d = (cnt_d == 4'd0) ? 4'h0 : 4'hB;
        end else if (state_d == ADDR) begin
            nib_sel = 4'(ADDR_NIBBLES - 1) - cnt_d;
            sio_d   = 4'(byte_addr >> {nib_sel, 2'b00});
        end

        vld_d = (state == STREAM) && !redir;
        enc_d = vld_d ? i_fe_mem_sio : 4'h0;
    end

    always_ff @(posedge i_fe_gck) begin
        if (i_fe_rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            fetch_addr      <= 16'h0000;
            o_fe_ctr        <= 2'd0;
            o_fe_enc        <= 4'h0;
            o_fe_enc_vld    <= 1'b0;
            o_fe_pc         <= 16'h0000;
            o_fe_mem_cs_n   <= 1'b1;
            o_fe_mem_sio    <= 4'h0;
            o_fe_mem_sio_oe <= 1'b0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            fetch_addr      <= fetch_addr_d;
            o_fe_ctr        <= o_fe_ctr + 2'd1;
            o_fe_enc        <= enc_d;
            o_fe_enc_vld    <= vld_d;
            o_fe_pc         <= pc_d;
            o_fe_mem_cs_n   <= cs_n_d;
            o_fe_mem_sio    <= sio_d;
            o_fe_mem_sio_oe <= oe_d;
        end
    end

endmodule

// File: tb/tb_idli_fetch_m.sv
// Directed bench for idli_fetch_m with a behavioural SQI SRAM answering fast-read (0x0B).
module tb_idli_fetch_m;

    logic        clk;
    logic        rst;
    logic        redir;
    logic [15:0] redir_addr;
    logic [1:0]  ctr;
    logic [3:0]  enc;
    logic        enc_vld;
    logic [15:0] pc;
    logic        cs_n;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic [3:0]  sram_in;

    int ntot  = 0;
    int nfail = 0;

    idli_fetch_m dut (
        .i_fe_gck        (clk),
        .i_fe_rst        (rst),
        .i_fe_redir      (redir),
        .i_fe_redir_addr (redir_addr),
        .o_fe_ctr        (ctr),
        .o_fe_enc        (enc),
        .o_fe_enc_vld    (enc_vld),
        .o_fe_pc         (pc),
        .o_fe_mem_cs_n   (cs_n),
        .o_fe_mem_sio    (sio_out),
        .o_fe_mem_sio_oe (sio_oe),
        .i_fe_mem_sio    (sram_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_val(input logic [15:0] w);
        case (w)
            16'h0000: return 16'h1234;
            16'h0001: return 16'hABCD;
            16'h0002: return 16'h0F00;
            16'h0003: return 16'h5678;
            16'h0100: return 16'h9C3E;
            16'h0101: return 16'h2468;
            16'hFFFF: return 16'h7E81;
            16'h0020: return 16'hC0DE;
            16'h0021: return 16'hBEEF;
            default:  return w ^ 16'hA5C3;
        endcase
    endfunction

    // SRAM model: counts cs_n-low cycles, shifts in the address, streams nibbles LSB-nibble first.
    int          bc = 0;
    logic [23:0] baddr = 24'h0;
    always @(negedge clk) begin
        int n;
        logic [15:0] w;
        if (cs_n) begin
            bc      = 0;
            sram_in = 4'h0;
        end else begin
            if (bc >= 2 && bc < 8) baddr = {baddr[19:0], sio_out};
            if (bc >= 10) begin
                n       = bc - 10;
                w       = baddr[16:1] + 16'(n / 4);
                sram_in = 4'(word_val(w) >> (4 * (n % 4)));
            end else begin
                sram_in = 4'h0;
            end
            bc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_redir(input logic [15:0] a);
        redir      = 1'b1;
        redir_addr = a;
        step();
        redir      = 1'b0;
    endtask

    task automatic wait_cs_fall(output bit ok);
        int k = 0;
        while (cs_n && k < 16) begin
            step();
            k++;
        end
        ok = !cs_n;
        if (!ok) chk("cs_fall_timeout", 32'(cs_n), 32'd0);
    endtask

    // From somewhere before the read: check command/address/dummy, then nw words. Ends at ctr==3 of the last word.
    task automatic expect_fetch(input logic [15:0] a, input int nw);
        bit          ok;
        logic [23:0] ba;
        logic [3:0]  exp_sio;
        logic [15:0] wv;
        ba = {7'b0, a, 1'b0};
        wait_cs_fall(ok);
        if (!ok) return;
        chk("cs_fall_ctr", 32'(ctr), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 1) exp_sio = 4'hB;
            else if (i >= 2 && i < 8) exp_sio = 4'(ba >> (4 * (7 - i)));
            else exp_sio = 4'h0;
            chk($sformatf("bus_sio[%0d]@%h", i, a), 32'(sio_out), 32'(exp_sio));
            chk($sformatf("bus_oe[%0d]@%h", i, a), 32'(sio_oe), (i < 8) ? 32'd1 : 32'd0);
            chk($sformatf("bus_cs[%0d]@%h", i, a), 32'(cs_n), 32'd0);
            step();
        end
        chk("first_stream_vld", 32'(enc_vld), 32'd0);
        for (int w = 0; w < nw; w++) begin
            wv = word_val(a + 16'(w));
            for (int k = 0; k < 4; k++) begin
                step();
                chk($sformatf("enc[%0d.%0d]@%h", w, k, a), 32'(enc), 32'(4'(wv >> (4 * k))));
                chk($sformatf("vld[%0d.%0d]@%h", w, k, a), 32'(enc_vld), 32'd1);
                chk($sformatf("pc[%0d.%0d]@%h", w, k, a), 32'(pc), 32'(a + 16'(w)));
                chk($sformatf("ctr[%0d.%0d]@%h", w, k, a), 32'(ctr), 32'(k));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctr"}, 32'(ctr), 32'd0);
        chk({tag, "_enc"}, 32'(enc), 32'd0);
        chk({tag, "_vld"}, 32'(enc_vld), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_cs_n"}, 32'(cs_n), 32'd1);
        chk({tag, "_sio"}, 32'(sio_out), 32'd0);
        chk({tag, "_oe"}, 32'(sio_oe), 32'd0);
    endtask

    initial begin
        bit ok;
        rst        = 1'b1;
        redir      = 1'b0;
        redir_addr = 16'h0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Reset release and sequential stream of words 0..2.
        expect_fetch(16'h0000, 3);

        // Mid-word redirect at ctr==1.
        step();
        step();
        chk("redir_ctr", 32'(ctr), 32'd1);
        pulse_redir(16'h0100);
        chk("redir_cs_n", 32'(cs_n), 32'd1);
        chk("redir_vld", 32'(enc_vld), 32'd0);
        chk("redir_enc", 32'(enc), 32'd0);
        chk("redir_oe", 32'(sio_oe), 32'd0);
        expect_fetch(16'h0100, 2);

        // Redirect to the last word; the wrap re-issues the read at 0.
        pulse_redir(16'hFFFF);
        expect_fetch(16'hFFFF, 1);
        step();
        chk("wrap_cs_n", 32'(cs_n), 32'd1);
        chk("wrap_vld", 32'(enc_vld), 32'd0);
        chk("wrap_ctr", 32'(ctr), 32'd0);
        expect_fetch(16'h0000, 1);

        // Two redirects during the address phase; the later one wins.
        pulse_redir(16'h0300);
        wait_cs_fall(ok);
        step();
        step();
        step();
        chk("addr_phase_oe", 32'(sio_oe), 32'd1);
        pulse_redir(16'h0010);
        chk("dbl_redir_cs_n", 32'(cs_n), 32'd1);
        step();
        pulse_redir(16'h0020);
        chk("dbl_redir2_cs_n", 32'(cs_n), 32'd1);
        expect_fetch(16'h0020, 2);

        // Reset mid-stream together with a redirect: reset wins.
        step();
        step();
        chk("pre_rst_vld", 32'(enc_vld), 32'd1);
        rst        = 1'b1;
        redir      = 1'b1;
        redir_addr = 16'h0500;
        step();
        rst   = 1'b0;
        redir = 1'b0;
        chk_reset_outputs("midrst");
        expect_fetch(16'h0000, 1);

        $display("%0d/%0d checks passed", ntot - nfail, ntot);
        $finish;
    end

endmodule
